// File: rtl/ysyx_22050243_line_fill_bridge.sv
// Icache line-refill responder: turns one 16-byte line request into a two-beat
// 64-bit AXI4 INCR read burst and returns the assembled 128-bit line.
module ysyx_22050243_line_fill_bridge #(
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   input  logic [63:0]  req_addr,
   output logic         res_valid,
   output logic [127:0] res_data,
   output logic         res_err,
   output logic         err_sticky,
   output logic         arvalid,
   input  logic         arready,
   output logic [31:0]  araddr,
   output logic [3:0]   arid,
   output logic [7:0]   arlen,
   output logic [2:0]   arsize,
   output logic [1:0]   arburst,
   input  logic         rvalid,
   output logic         rready,
   input  logic [63:0]  rdata,
   input  logic [1:0]   rresp,
   input  logic         rlast
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] AR   = 3'd1;
   localparam logic [2:0] R0   = 3'd2;
   localparam logic [2:0] R1   = 3'd3;
   localparam logic [2:0] RESP = 3'd4;
   localparam logic [2:0] DONE = 3'd5;

   logic [2:0] state;
   logic       err;
   logic       beat0_err;
   logic       beat1_err;
   logic       unused_addr_bits;

   assign arid    = AXI_ID;
   assign arlen   = 8'd1;
   assign arsize  = 3'b011;
   assign arburst = 2'b01;

   assign unused_addr_bits = ^{req_addr[63:32], req_addr[3:0]};

   assign beat0_err = (rresp != 2'b00);
   // A missing rlast on beat 1 is reported as an error rather than waited on.
   assign beat1_err = err | (rresp != 2'b00) | ~rlast;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         err        <= 1'b0;
         arvalid    <= 1'b0;
         araddr     <= '0;
         rready     <= 1'b0;
         res_valid  <= 1'b0;
         res_err    <= 1'b0;
         err_sticky <= 1'b0;
         res_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  araddr  <= {req_addr[31:4], 4'h0};
                  arvalid <= 1'b1;
                  err     <= 1'b0;
                  state   <= AR;
               end
            end
            AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= R0;
               end
            end
            R0: begin
               if (rvalid) begin
                  res_data[63:0] <= rdata;
                  if (rlast) begin
                     // Burst ended one beat early: deliver a half-empty line flagged as bad.
                     res_data[127:64] <= '0;
                     rready           <= 1'b0;
                     res_valid        <= req_valid;
                     res_err          <= 1'b1;
                     err              <= 1'b1;
                     err_sticky       <= 1'b1;
                     state            <= RESP;
                  end else begin
                     err        <= err | beat0_err;
                     err_sticky <= err_sticky | beat0_err;
                     state      <= R1;
                  end
               end
            end
            R1: begin
               if (rvalid) begin
                  res_data[127:64] <= rdata;
                  rready           <= 1'b0;
                  res_valid        <= req_valid;
                  res_err          <= beat1_err;
                  err              <= beat1_err;
                  err_sticky       <= err_sticky | beat1_err;
                  state            <= RESP;
               end
            end
            RESP: begin
               // The pulse is registered on beat-1 acceptance; a withdrawn request skips DONE.
               res_valid <= 1'b0;
               state     <= res_valid ? DONE : IDLE;
            end
            DONE: begin
               if (!req_valid) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22050243_line_fill_bridge.sv
// Directed self-checking bench for the icache line-fill bridge.
module tb_ysyx_22050243_line_fill_bridge;

   logic         clk;
   logic         rst;
   logic         req_valid;
   logic [63:0]  req_addr;
   logic         res_valid;
   logic [127:0] res_data;
   logic         res_err;
   logic         err_sticky;
   logic         arvalid;
   logic         arready;
   logic [31:0]  araddr;
   logic [3:0]   arid;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         rvalid;
   logic         rready;
   logic [63:0]  rdata;
   logic [1:0]   rresp;
   logic         rlast;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
   localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;

   ysyx_22050243_line_fill_bridge #(.AXI_ID(4'd5)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr),
      .res_valid(res_valid), .res_data(res_data), .res_err(res_err), .err_sticky(err_sticky),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // Zero-wait fill from IDLE; captures what was seen for the calling test to judge.
   task automatic run_fill(input logic [63:0] addr,
                           input logic [63:0] d0, input logic [1:0] rs0, input logic l0,
                           input logic [63:0] d1, input logic [1:0] rs1, input logic l1,
                           output logic [31:0] g_araddr, output logic g_arvalid,
                           output logic g_rready, output logic g_first,
                           output logic [127:0] g_data, output logic g_err,
                           output logic g_sticky, output int g_pulses);
      req_valid = 1'b1; req_addr = addr; arready = 1'b1;
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      @(negedge clk);
      g_arvalid = arvalid; g_araddr = araddr;
      rvalid = 1'b1; rdata = d0; rresp = rs0; rlast = l0;
      @(negedge clk);
      g_rready = rready;
      if (!l0) begin
         @(negedge clk);
         rdata = d1; rresp = rs1; rlast = l1;
      end
      @(negedge clk);
      g_first = res_valid; g_data = res_data; g_err = res_err; g_sticky = err_sticky;
      g_pulses = int'(res_valid);
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0; req_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         g_pulses += int'(res_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; arready = 1'b0;
      rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({arvalid, rready, res_valid, res_err, err_sticky} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000", {arvalid, rready, res_valid, res_err, err_sticky});
      end
      checks++;
      if (res_data !== 128'h0 || araddr !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got data=%h addr=%h expected 0", res_data, araddr);
      end
      checks++;
      if ({arid, arlen, arsize, arburst} !== {4'd5, 8'd1, 3'b011, 2'b01}) begin
         errors++;
         $display("FAIL ar_consts: got id=%h len=%h size=%h burst=%h expected 5/01/3/1", arid, arlen, arsize, arburst);
      end
   endtask

   task automatic test_basic();
      logic [31:0] a; logic av, rr, first, e, s; logic [127:0] d; int p;
      run_fill(64'h0000_0000_8000_0128, D1, 2'b00, 1'b0, D2, 2'b00, 1'b1, a, av, rr, first, d, e, s, p);
      checks++;
      if (av !== 1'b1 || a !== 32'h8000_0120) begin
         errors++;
         $display("FAIL basic_ar: got arvalid=%b araddr=%h expected 1/80000120", av, a);
      end
      checks++;
      if (rr !== 1'b1) begin
         errors++;
         $display("FAIL basic_rready: got %b expected 1", rr);
      end
      checks++;
      if (first !== 1'b1 || p != 1) begin
         errors++;
         $display("FAIL basic_pulse: got first=%b pulses=%0d expected 1/1", first, p);
      end
      checks++;
      if (d !== {D2, D1} || e !== 1'b0) begin
         errors++;
         $display("FAIL basic_line: got %h err=%b expected %h err=0", d, e, {D2, D1});
      end
   endtask

   task automatic test_backpressure();
      int bad_addr = 0;
      int pulses = 0;
      req_valid = 1'b1; req_addr = 64'h0000_0000_8000_3456; arready = 1'b0; rvalid = 1'b0;
      for (int unsigned i = 0; i < 6; i++) begin
         @(negedge clk);
         if (arvalid !== 1'b1 || araddr !== 32'h8000_3450) bad_addr++;
         req_addr = 64'h0000_0000_1234_5678 + 64'(i);
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0; rvalid = 1'b1; rdata = 64'hAAAA_0000_BBBB_0001; rresp = 2'b00; rlast = 1'b0;
      @(negedge clk);
      rvalid = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         @(negedge clk);
         pulses += int'(res_valid);
         if (rready !== 1'b1) bad_addr++;
      end
      rvalid = 1'b1; rdata = 64'hCCCC_0000_DDDD_0002; rlast = 1'b1;
      @(negedge clk);
      pulses += int'(res_valid);
      checks++;
      if (res_data !== {64'hCCCC_0000_DDDD_0002, 64'hAAAA_0000_BBBB_0001} || res_err !== 1'b0) begin
         errors++;
         $display("FAIL bp_line: got %h err=%b", res_data, res_err);
      end
      rvalid = 1'b0; rlast = 1'b0; req_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         pulses += int'(res_valid);
      end
      checks++;
      if (bad_addr != 0) begin
         errors++;
         $display("FAIL bp_stable: got %0d bad cycles expected 0", bad_addr);
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL bp_pulses: got %0d expected 1", pulses);
      end
   endtask

   task automatic test_error();
      logic [31:0] a; logic av, rr, first, e, s; logic [127:0] d; int p;
      run_fill(64'h0000_0000_8000_0200, D1, 2'b00, 1'b0, D2, 2'b10, 1'b1, a, av, rr, first, d, e, s, p);
      checks++;
      if (first !== 1'b1 || e !== 1'b1 || s !== 1'b1 || p != 1) begin
         errors++;
         $display("FAIL err_resp: got valid=%b err=%b sticky=%b pulses=%0d expected 1/1/1/1", first, e, s, p);
      end
      run_fill(64'h0000_0000_8000_0210, D2, 2'b00, 1'b0, D1, 2'b00, 1'b1, a, av, rr, first, d, e, s, p);
      checks++;
      if (first !== 1'b1 || e !== 1'b0 || s !== 1'b1 || d !== {D1, D2}) begin
         errors++;
         $display("FAIL err_clean_after: got valid=%b err=%b sticky=%b data=%h", first, e, s, d);
      end
      checks++;
      if (err_sticky !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky_hold: got %b expected 1", err_sticky);
      end
   endtask

   task automatic test_malformed();
      logic [31:0] a; logic av, rr, first, e, s; logic [127:0] d; int p;
      run_fill(64'h0000_0000_8000_0300, 64'h3333_4444_5555_6666, 2'b00, 1'b1, D2, 2'b00, 1'b1,
               a, av, rr, first, d, e, s, p);
      checks++;
      if (first !== 1'b1 || e !== 1'b1 || p != 1) begin
         errors++;
         $display("FAIL malformed_flag: got valid=%b err=%b pulses=%0d expected 1/1/1", first, e, p);
      end
      checks++;
      if (d !== {64'h0, 64'h3333_4444_5555_6666}) begin
         errors++;
         $display("FAIL malformed_data: got %h expected %h", d, {64'h0, 64'h3333_4444_5555_6666});
      end
      run_fill(64'h0000_0000_8000_0310, D1, 2'b00, 1'b0, D1, 2'b00, 1'b1, a, av, rr, first, d, e, s, p);
      checks++;
      if (av !== 1'b1 || a !== 32'h8000_0310 || first !== 1'b1 || e !== 1'b0) begin
         errors++;
         $display("FAIL malformed_recover: got arvalid=%b addr=%h valid=%b err=%b", av, a, first, e);
      end
   endtask

   task automatic test_withdrawn();
      logic [31:0] a; logic av, rr, first, e, s; logic [127:0] d; int p;
      int bad = 0;
      req_valid = 1'b1; req_addr = 64'h0000_0000_8000_0400; arready = 1'b1; rvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (rready !== 1'b1) bad++;
      arready = 1'b0; rvalid = 1'b1; rdata = D1; rresp = 2'b00; rlast = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      if (rready !== 1'b1) bad++;
      rdata = D2; rlast = 1'b1;
      @(negedge clk);
      if (res_valid !== 1'b0 || rready !== 1'b0) bad++;
      rvalid = 1'b0; rlast = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || arvalid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL withdrawn_drain: got %0d bad cycles expected 0", bad);
      end
      run_fill(64'h0000_0000_8000_0410, D2, 2'b00, 1'b0, D2, 2'b00, 1'b1, a, av, rr, first, d, e, s, p);
      checks++;
      if (av !== 1'b1 || a !== 32'h8000_0410 || p != 1 || d !== {D2, D2}) begin
         errors++;
         $display("FAIL withdrawn_next: got arvalid=%b addr=%h pulses=%0d data=%h", av, a, p, d);
      end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      req_valid = 1'b1; req_addr = 64'h0000_0000_8000_0500; arready = 1'b1; rvalid = 1'b0;
      @(negedge clk);
      rvalid = 1'b1; rdata = D1; rresp = 2'b00; rlast = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rdata = D2; rlast = 1'b1;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_pulse: got %b expected 1", res_valid);
      end
      rvalid = 1'b0; rlast = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (arvalid !== 1'b0 || res_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL b2b_no_reissue: got %0d bad cycles expected 0", bad);
      end
      req_valid = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 64'h0000_0000_8000_0530;
      checks++;
      if (arvalid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap: got arvalid=%b expected 0", arvalid);
      end
      @(negedge clk);
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h8000_0530) begin
         errors++;
         $display("FAIL b2b_second_ar: got arvalid=%b addr=%h expected 1/80000530", arvalid, araddr);
      end
      rvalid = 1'b1; rdata = D2; rlast = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rdata = D1; rlast = 1'b1;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== {D1, D2}) begin
         errors++;
         $display("FAIL b2b_second_line: got valid=%b data=%h", res_valid, res_data);
      end
      rvalid = 1'b0; rlast = 1'b0; arready = 1'b0; req_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [31:0] a; logic av, rr, first, e, s; logic [127:0] d; int p;
      req_valid = 1'b1; req_addr = 64'h0000_0000_8000_0600; arready = 1'b1; rvalid = 1'b0;
      @(negedge clk);
      rvalid = 1'b1; rdata = D1; rresp = 2'b00; rlast = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_in_r1: got rready=%b expected 1", rready);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({arvalid, rready, res_valid, res_err, err_sticky} !== 5'b0) begin
         errors++;
         $display("FAIL rstmid_ctrl: got %b expected 00000", {arvalid, rready, res_valid, res_err, err_sticky});
      end
      checks++;
      if (res_data !== 128'h0 || araddr !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_data: got data=%h addr=%h expected 0", res_data, araddr);
      end
      req_valid = 1'b0; rvalid = 1'b0; arready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_fill(64'h0000_0000_8000_0618, D2, 2'b00, 1'b0, D1, 2'b00, 1'b1, a, av, rr, first, d, e, s, p);
      checks++;
      if (av !== 1'b1 || a !== 32'h8000_0610 || p != 1 || d !== {D1, D2} || e !== 1'b0 || s !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_fresh: got arvalid=%b addr=%h pulses=%0d data=%h err=%b sticky=%b",
                  av, a, p, d, e, s);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_error();
      test_malformed();
      test_withdrawn();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_22050243_line_fill_bridge.md
# ysyx_22050243_line_fill_bridge

Memory-side responder for the instruction cache's line-refill request port. It accepts one 16-byte line request (`req_valid`/`req_addr`) and converts it into a single two-beat AXI4 INCR read burst of 64-bit beats. It assembles the two beats into a 128-bit line and returns it with a one-cycle `res_valid` pulse. It sits between the icache and the AXI crossbar; the AR/R channels of this block are the only path from the icache to memory.

## Interface
- `AXI_ID`, default 4'd0: constant driven on `arid`.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: line request. The cache holds it high until it samples `res_valid`.
- `req_addr` in 64: request address. Only bits [31:4] are used.
- `res_valid` out 1: one-cycle pulse; the line is available on `res_data`.
- `res_data` out 128: assembled line. Beat 0 goes to [63:0], beat 1 to [127:64].
- `res_err` out 1: valid with `res_valid`; 1 if any beat had `rresp`≠OKAY or the burst was malformed.
- `err_sticky` out 1: set on any error; cleared only by `rst`.
- `arvalid` out 1, `arready` in 1, `araddr` out 32, `arid` out 4, `arlen` out 8, `arsize` out 3, `arburst` out 2: AXI4 read-address channel.
- `rvalid` in 1, `rready` out 1, `rdata` in 64, `rresp` in 2, `rlast` in 1: AXI4 read-data channel. `rid` is not checked.

## Operation
- States: IDLE, AR, R0, R1, RESP, DONE.
- **IDLE**
  - On `req_valid`=1: latch `{req_addr[31:4],4'h0}` into the address register and go to AR.
- **AR**
  - Drive `arvalid`=1 with the latched address, `arlen`=8'd1, `arsize`=3'b011, `arburst`=2'b01, `arid`=AXI_ID.
  - On `arvalid`&`arready`: go to R0.
  - `araddr` is stable while `arvalid` is high, even if `req_addr` changes.
- **R0**
  - `rready`=1. On `rvalid`: capture `rdata` into `res_data[63:0]`; record an error if `rresp`≠2'b00.
  - If `rlast`=1 on this beat: record an error, zero `res_data[127:64]`, go to RESP.
  - Otherwise go to R1.
- **R1**
  - `rready`=1. On `rvalid`: capture `rdata` into [127:64]; record an error if `rresp`≠0 or `rlast`=0.
  - Go to RESP.
  - The bridge never waits for extra beats. A missing `rlast` is an error, not a hang.
- **RESP**
  - If `req_valid`=1: pulse `res_valid`=1 for exactly one cycle, with `res_err` equal to the recorded error; go to DONE.
  - If `req_valid`=0 (request withdrawn during the burst): no pulse; go to IDLE. `err_sticky` still updates.
- **DONE**
  - Wait until `req_valid`=0, then go to IDLE.
  - This prevents a request that is still asserted in the pulse cycle from being reissued.
- The error flag is cleared on entry to AR. `err_sticky` ORs in every recorded error.
- `res_data` holds its value until the next beat-0 capture.

## Timing
- All outputs are registered.
- Reset values: `arvalid`=0, `rready`=0, `res_valid`=0, `res_err`=0, `err_sticky`=0, `res_data`=0, `araddr`=0. `arlen`, `arsize`, `arburst` and `arid` are constants. State = IDLE.
- Cycle-level latency:
  - `req_valid` sampled at edge N gives `arvalid`=1 in cycle N+1.
  - An AR handshake at edge M gives `rready`=1 from cycle M+1.
  - Beat 1 accepted at edge K gives `res_valid`=1 in cycle K+1.
- Minimum latency, request to `res_valid`: 4 cycles, with zero-wait `arready`/`rvalid`.
- `rready` is 0 in all states except R0 and R1. `arvalid` is 0 in all states except AR.
- Back-to-back requests: a new request is accepted in IDLE no earlier than one cycle after `req_valid` drops.
- `rst` asserted mid-burst: all outputs return to reset values immediately (asynchronously). Any outstanding burst is abandoned. The system guarantees the interconnect is reset together with this block.
- Throughput: one line at a time; no outstanding-transaction overlap.

## Test plan
- **Basic fill.** Hold `req_valid` with `req_addr`=0x8000_0128. Interconnect ready immediately; returns 0x1111..1111 then 0x2222..2222 (`rlast` on beat 2).
  - Expect `araddr`=0x8000_0120, `arlen`=1, `arsize`=3.
  - Expect `res_valid` for 1 cycle with `res_data`=0x2222..2222_1111..1111, `res_err`=0, 4 cycles after the request.
- **Backpressure.** `arready` delayed 5 cycles; 3 idle cycles between beats.
  - Expect `araddr` stable throughout, the correct line, and a single `res_valid` pulse.
- **Error response.** Beat 1 returns `rresp`=2'b10.
  - Expect `res_valid`=1 with `res_err`=1 and `err_sticky`=1, held until `rst`.
  - A following clean request gives `res_err`=0 with `err_sticky` still 1.
- **Malformed burst.** `rlast`=1 on beat 0.
  - Expect `res_valid` with `res_data[127:64]`=0 and `res_err`=1. Also expect no hang: IDLE is reached after `req_valid` drops.
- **Withdrawn request.** `req_valid` drops between AR handshake and beat 1.
  - Expect the burst to be drained (`rready` high for both beats), no `res_valid`, and IDLE afterwards.
- **Reset mid-burst.** Assert `rst` during R1.
  - Expect `arvalid`, `rready` and `res_valid` at 0 in the same cycle, and state IDLE. A fresh request after reset completes normally.
